// File: rtl/if_id_pkg.sv
// if_id_pkg: shared types and constants for the IF->ID pipeline boundary.
package if_id_pkg;
    localparam int IFID_XLEN = 64;
    localparam int IFID_ILEN = 32;
    localparam int IFID_EXC_W = 2;
    localparam logic [31:0] RV_NOP = 32'h00000013;
    localparam int EXC_MISALIGN = 0;
    localparam int EXC_ACCESS = 1;
    typedef struct packed {
        logic [IFID_ILEN-1:0]  inst;
        logic [IFID_XLEN-1:0]  pc;
        logic [IFID_XLEN-1:0]  pcadd4;
        logic [IFID_EXC_W-1:0] exc;
    } ifid_payload_t;
    // Encoded as {skid_v, main_v}.
    typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} skid_state_t;
endpackage

// File: rtl/if_id_skid_if.sv
// if_id_skid_if: fetch-side and decode-side handshake bundle of the IF->ID stage.
interface if_id_skid_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int EXC_W = 2,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [ILEN-1:0]  in_inst;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_pcadd4;
    logic [EXC_W-1:0] in_exc;
    logic             out_valid;
    logic             out_ready;
    logic [ILEN-1:0]  out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [XLEN-1:0]  out_pcadd4;
    logic [EXC_W-1:0] out_exc;
    logic [CNT_W-1:0] stall_cnt;
    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_pcadd4, in_exc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_pcadd4, out_exc, stall_cnt
    );
    modport master (
        output flush, in_valid, in_inst, in_pc, in_pcadd4, in_exc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_pcadd4, out_exc, stall_cnt
    );
endinterface

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry valid/ready buffer with registered in_ready and flush.
module skid_buffer
    import if_id_pkg::*;
#(
    parameter int W = $bits(ifid_payload_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    skid_state_t  state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         in_fire, out_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        in_fire  = in_valid & in_ready_q;
        out_fire = state_q[0] & out_ready;
        state_d  = flush ? EMPTY :
                   state_q == EMPTY ? (in_fire ? ONE : EMPTY) :
                   state_q == ONE   ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
                   (out_fire ? ONE : FULL);
        in_ready_d = !state_d[1];
        // Main refills from skid when draining FULL, otherwise from the fetch port.
        main_d = (!flush && (state_q == FULL ? out_fire : in_fire && (state_q == EMPTY || out_fire))) ?
                 (state_q == FULL ? skid_q : in_data) : main_q;
        skid_d = (!flush && state_q == ONE && in_fire && !out_fire) ? in_data : skid_q;
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = state_q[0];
        out_data  = main_q;
    end
endmodule

// File: rtl/if_id_skid.sv
// if_id_skid: IF->ID boundary; skid-buffered payload, NOP/zero output masking and stall counter.
module if_id_skid
    import if_id_pkg::*;
#(
    parameter int              XLEN     = IFID_XLEN,
    parameter int              ILEN     = IFID_ILEN,
    parameter int              EXC_W    = IFID_EXC_W,
    parameter logic [ILEN-1:0] NOP_INST = RV_NOP,
    parameter int              CNT_W    = 16
) (
    input logic         clk,
    input logic         rst,
    if_id_skid_if.slave bus
);
    localparam int W = ILEN + 2 * XLEN + EXC_W;

    logic [W-1:0]     in_data, out_data;
    logic             out_valid;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign in_data = {bus.in_inst, bus.in_pc, bus.in_pcadd4, bus.in_exc};

    skid_buffer #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    always_comb begin
        stall_cnt_d    = (out_valid && !bus.out_ready && !bus.flush && stall_cnt_q != '1) ?
                         stall_cnt_q + 1'b1 : stall_cnt_q;
        bus.out_valid  = out_valid;
        bus.out_inst   = out_valid ? out_data[W-1 -: ILEN] : NOP_INST;
        bus.out_pc     = out_valid ? out_data[2*XLEN+EXC_W-1 -: XLEN] : '0;
        bus.out_pcadd4 = out_valid ? out_data[XLEN+EXC_W-1 -: XLEN] : '0;
        bus.out_exc    = out_valid ? out_data[EXC_W-1:0] : '0;
        bus.stall_cnt  = stall_cnt_q;
    end
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: directed bench for if_id_skid against a queue-based reference model.
module tb_if_id_skid;
    import if_id_pkg::*;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_id_skid_if #(.XLEN(IFID_XLEN), .ILEN(IFID_ILEN), .EXC_W(IFID_EXC_W), .CNT_W(CNT_W)) bus ();
    if_id_skid #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    ifid_payload_t q[$];
    bit m_rdy = 1'b1;
    int m_cnt = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdy = 1'b1;
        m_cnt = 0;
    endtask

    // Word-level model: a FIFO of at most two words, readiness means room was left after the edge.
    task automatic model_edge();
        bit inf, outf;
        if (rst) begin
            model_reset();
            return;
        end
        inf  = bus.in_valid && m_rdy;
        outf = q.size() > 0 && bus.out_ready;
        if (q.size() > 0 && !bus.out_ready && !bus.flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (bus.flush) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back('{bus.in_inst, bus.in_pc, bus.in_pcadd4, bus.in_exc});
        end
        m_rdy = q.size() < 2;
    endtask

    task automatic compare();
        bit v;
        v = q.size() != 0;
        chk("m_out_valid", bus.out_valid, v);
        chk("m_out_inst", bus.out_inst, v ? q[0].inst : RV_NOP);
        chk("m_out_pc", bus.out_pc, v ? q[0].pc : 64'd0);
        chk("m_out_pcadd4", bus.out_pcadd4, v ? q[0].pcadd4 : 64'd0);
        chk("m_out_exc", bus.out_exc, v ? q[0].exc : 2'd0);
        chk("m_in_ready", bus.in_ready, m_rdy);
        chk("m_stall_cnt", bus.stall_cnt, m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic push(input logic [63:0] pc, input logic [1:0] exc);
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'hA000_0000 | pc[31:0];
        bus.in_pc     = pc;
        bus.in_pcadd4 = pc + 64'd4;
        bus.in_exc    = exc;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_inst", bus.out_inst, 32'h00000013);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        idle();
        bus.flush = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_pc = '0;
        bus.in_pcadd4 = '0;
        bus.in_exc = '0;
        @(negedge clk);
        do_reset();

        // Streaming with 1-cycle latency
        bus.out_ready = 1'b1;
        push(64'h1000, 2'b00); cycle();
        chk("s_pc0", bus.out_pc, 64'h1000);
        chk("s_rdy0", bus.in_ready, 1);
        push(64'h1004, 2'b00); cycle();
        chk("s_pc1", bus.out_pc, 64'h1004);
        push(64'h1008, 2'b00); cycle();
        chk("s_pc2", bus.out_pc, 64'h1008);
        chk("s_pcadd4", bus.out_pcadd4, 64'h100c);
        chk("s_inst", bus.out_inst, 32'hA000_1008);
        bus.out_ready = 1'b0;
        push(64'h100c, 2'b00); cycle();
        chk("s_hold", bus.out_pc, 64'h1008);

        // Reset mid-stream, visible before the next clock edge
        do_reset();

        // Back-pressure into FULL and drain in order
        push(64'h1000, 2'b00); cycle();
        chk("bp_pc", bus.out_pc, 64'h1000);
        chk("bp_cnt0", bus.stall_cnt, 0);
        push(64'h1004, 2'b00); cycle();
        chk("bp_full_rdy", bus.in_ready, 0);
        chk("bp_cnt1", bus.stall_cnt, 1);
        idle(); cycle();
        chk("bp_cnt2", bus.stall_cnt, 2);
        cycle();
        chk("bp_cnt3", bus.stall_cnt, 3);
        chk("bp_pc_held", bus.out_pc, 64'h1000);
        bus.out_ready = 1'b1; cycle();
        chk("bp_drain_pc", bus.out_pc, 64'h1004);
        chk("bp_drain_rdy", bus.in_ready, 1);
        cycle();
        chk("bp_empty", bus.out_valid, 0);

        // Flush in FULL and in ONE with a word being accepted
        do_reset();
        bus.out_ready = 1'b0;
        push(64'h1000, 2'b00); cycle();
        push(64'h1004, 2'b00); cycle();
        push(64'h2000, 2'b00); bus.flush = 1'b1; cycle();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_inst", bus.out_inst, 32'h00000013);
        chk("fl_rdy", bus.in_ready, 1);
        chk("fl_cnt", bus.stall_cnt, 1);
        bus.flush = 1'b0; idle(); cycle();
        chk("fl_no2000", bus.out_valid, 0);
        push(64'h1010, 2'b00); cycle();
        push(64'h2004, 2'b00); bus.flush = 1'b1; cycle();
        bus.flush = 1'b0; idle(); bus.out_ready = 1'b1; cycle();
        chk("fl_drop", bus.out_valid, 0);

        // Exception flags travel with their word
        do_reset();
        bus.out_ready = 1'b1;
        push(64'h3002, 2'b10); cycle();
        chk("ex_exc", bus.out_exc, 2'b10);
        chk("ex_pc", bus.out_pc, 64'h3002);
        idle(); cycle();
        chk("ex_exc0", bus.out_exc, 0);

        // Stall counter saturation survives a flush
        do_reset();
        bus.out_ready = 1'b0;
        push(64'h1000, 2'b00); cycle();
        idle();
        repeat (20) cycle();
        chk("sat_cnt", bus.stall_cnt, 15);
        bus.flush = 1'b1; cycle();
        chk("sat_flush_cnt", bus.stall_cnt, 15);
        chk("sat_flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0; cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
